mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between CPU and I/O; grant 1 cycle after req sample.
// Latency: writes 2 cycles, reads RD_LAT+2 cycles to rvalid; losers hold req and are served next IDLE.
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_gnt,
  output logic              io_rvalid,
  output logic [DATA_W-1:0] io_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                win_io;
  logic                prio_io;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    cnt;
  logic                pick_io;
  logic                any_req;
  logic                capture;

  // IO wins only if CPU is idle or CPU was served last.
  assign any_req = cpu_req | io_req;
  assign pick_io = io_req & (~cpu_req | prio_io);
  assign capture = (state == WAIT) && (cnt == CNT_W'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = we_q ? IDLE : WAIT;
      WAIT:    if (cnt == CNT_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      win_io     <= 1'b0;
      prio_io    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      cpu_rdata  <= '0;
      io_rdata   <= '0;
      cpu_rvalid <= 1'b0;
      io_rvalid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cpu_rvalid <= capture & ~win_io;
      io_rvalid  <= capture & win_io;
      case (state)
        IDLE: begin
          if (any_req) begin
            win_io  <= pick_io;
            prio_io <= ~pick_io;
            we_q    <= pick_io ? io_we    : cpu_we;
            addr_q  <= pick_io ? io_addr  : cpu_addr;
            wdata_q <= pick_io ? io_wdata : cpu_wdata;
          end
        end
        ACCESS: begin
          if (!we_q) cnt <= CNT_W'(RD_LAT);
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (capture) begin
            if (win_io) io_rdata  <= mem_q;
            else        cpu_rdata <= mem_q;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign cpu_gnt   = (state == ACCESS) & ~win_io;
  assign io_gnt    = (state == ACCESS) & win_io;
  assign mem_wren  = (state == ACCESS) & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule
